// File: rtl/reg_bank_write_port.sv
// Write side of the 8-entry register file: address-decoded writes plus a
// sequencer that clears the bank one entry per cycle on request.
module reg_bank_write_port #(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       WA,
    input  logic [WIDTH-1:0] WDin,
    input  logic             WE,
    input  logic             CLR_REQ,
    output logic             BUSY,
    output logic             WACK,
    output logic [WIDTH-1:0] Dout0,
    output logic [WIDTH-1:0] Dout1,
    output logic [WIDTH-1:0] Dout2,
    output logic [WIDTH-1:0] Dout3,
    output logic [WIDTH-1:0] Dout4,
    output logic [WIDTH-1:0] Dout5,
    output logic [WIDTH-1:0] Dout6,
    output logic [WIDTH-1:0] Dout7
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e           state_q;
    logic [2:0]       cnt_q;
    logic             busy_q;
    logic             wack_q;
    logic [WIDTH-1:0] mem_q [8];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            wack_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    wack_q <= 1'b0;
                    // Clear request wins over a simultaneous write.
                    if (CLR_REQ) begin
                        state_q <= StClear;
                        cnt_q   <= 3'd0;
                        busy_q  <= 1'b1;
                    end else if (WE) begin
                        mem_q[WA] <= WDin;
                        wack_q    <= 1'b1;
                    end
                end
                StClear: begin
                    wack_q       <= 1'b0;
                    mem_q[cnt_q] <= RST_VAL;
                    cnt_q        <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    wack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY  = busy_q;
    assign WACK  = wack_q;
    assign Dout0 = mem_q[0];
    assign Dout1 = mem_q[1];
    assign Dout2 = mem_q[2];
    assign Dout3 = mem_q[3];
    assign Dout4 = mem_q[4];
    assign Dout5 = mem_q[5];
    assign Dout6 = mem_q[6];
    assign Dout7 = mem_q[7];

endmodule

// File: tb/tb_reg_bank_write_port.sv
// Directed self-checking bench for reg_bank_write_port.
module tb_reg_bank_write_port;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [2:0]       wa;
    logic [WIDTH-1:0] wdin;
    logic             we;
    logic             clr_req;
    logic             busy;
    logic             wack;
    logic [WIDTH-1:0] dout [8];

    int n_checks;
    int n_fail;
    int exp_mem [8];

    reg_bank_write_port #(
        .WIDTH   (WIDTH),
        .RST_VAL (4'd0)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .WA      (wa),
        .WDin    (wdin),
        .WE      (we),
        .CLR_REQ (clr_req),
        .BUSY    (busy),
        .WACK    (wack),
        .Dout0   (dout[0]),
        .Dout1   (dout[1]),
        .Dout2   (dout[2]),
        .Dout3   (dout[3]),
        .Dout4   (dout[4]),
        .Dout5   (dout[5]),
        .Dout6   (dout[6]),
        .Dout7   (dout[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_dout%0d", tag, i), int'(dout[i]), exp_mem[i]);
        end
    endtask

    // Stand-in for the downstream 8:1 read mux.
    function automatic int read_mux(input int ra);
        return int'(dout[ra]);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wa       = 3'd0;
        wdin     = '0;
        we       = 1'b0;
        clr_req  = 1'b0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 0;

        // 1: reset before any clock edge
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_wack", int'(wack), 0);
        check_all("rst");
        rst = 1'b0;

        // 2: fill 10..3
        for (int i = 0; i < 8; i++) begin
            we   = 1'b1;
            wa   = 3'(i);
            wdin = 4'(10 - i);
            tick();
            exp_mem[i] = 10 - i;
            check($sformatf("fill_wack%0d", i), int'(wack), 1);
            check($sformatf("fill_dout%0d", i), int'(dout[i]), 10 - i);
        end
        we = 1'b0;
        tick();
        check("fill_wack_drop", int'(wack), 0);
        check_all("fill");
        for (int ra = 0; ra < 5; ra++) begin
            check($sformatf("mux_ra%0d", ra), read_mux(ra), 10 - ra);
        end

        // 3: overwrite same address, last wins
        we = 1'b1; wa = 3'd3; wdin = 4'd15;
        tick();
        wdin = 4'd1;
        tick();
        we = 1'b0;
        exp_mem[3] = 1;
        check_all("ovr");

        // 4: clear sequence with a write attempted while busy
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_busy_start", int'(busy), 1);
        check("clr_wack_start", int'(wack), 0);
        we = 1'b1; wa = 3'd2; wdin = 4'd9;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_mem[k] = 0;
            check($sformatf("clr_dout%0d", k), int'(dout[k]), 0);
            check($sformatf("clr_wack%0d", k), int'(wack), 0);
            if (k < 7) begin
                check($sformatf("clr_busy%0d", k), int'(busy), 1);
                check($sformatf("clr_next%0d", k + 1), int'(dout[k + 1]), exp_mem[k + 1]);
            end else begin
                check("clr_busy_end", int'(busy), 0);
            end
        end
        we = 1'b0;
        check_all("clr_done");

        // 5: write colliding with clear request
        we = 1'b1; wa = 3'd5; wdin = 4'd7;
        tick();
        exp_mem[5] = 7;
        wdin = 4'd12; clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0;
        check("col_wack", int'(wack), 0);
        check("col_busy", int'(busy), 1);
        check("col_dout5_held", int'(dout[5]), 7);
        for (int k = 0; k < 8; k++) tick();
        exp_mem[5] = 0;
        check("col_busy_end", int'(busy), 0);
        check("col_dout5", int'(dout[5]), 0);

        // 6: reset in the middle of a clear
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 3'(i); wdin = 4'(i + 1);
            tick();
        end
        we = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("mid_dout3_before", int'(dout[3]), 4);
        check("mid_busy_before", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_mem[i] = 0;
        check("mid_busy", int'(busy), 0);
        check("mid_wack", int'(wack), 0);
        check_all("mid");
        tick();
        rst = 1'b0;
        we = 1'b1; wa = 3'd6; wdin = 4'd11;
        tick();
        we = 1'b0;
        exp_mem[6] = 11;
        check("post_wack", int'(wack), 1);
        check("post_busy", int'(busy), 0);
        check_all("post");
        tick();
        check("post_wack_drop", int'(wack), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
